// File: rtl/branch_recovery_ctrl_pkg.sv
// Shared types, widths and the wrap-aware age compare for the branch recovery controller.
package branch_recovery_ctrl_pkg;

    localparam int BRC_SQN_W     = 7;
    localparam int BRC_FETCHID_W = 3;
    localparam int BRC_PC_W      = 31;

    typedef struct packed {
        logic [BRC_SQN_W-1:0]     sqN;
        logic                     flush;
        logic [BRC_FETCHID_W-1:0] fetchID;
        logic [BRC_PC_W-1:0]      dstPC;
    } BrReq_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        REPLAY     = 2'd2,
        DRAIN      = 2'd3
    } BrCtrlState_t;

    // a is older than b when (a - b) is negative modulo 2^SQN_W; live sqNs span under half range.
    function automatic logic sqn_older(input logic [BRC_SQN_W-1:0] a,
                                       input logic [BRC_SQN_W-1:0] b);
        logic [BRC_SQN_W-1:0] diff;
        diff = a - b;
        return diff[BRC_SQN_W-1];
    endfunction

endpackage

// File: rtl/branch_recovery_ctrl_oldest_sel.sv
// Combinational age-compare tree: picks the oldest valid request, lower port index on ties.
// NUM_SRC must be a power of two; node n combines children 2n (lower ports) and 2n+1.
module branch_oldest_sel
    import branch_recovery_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]                valid,
    input  logic [NUM_SRC-1:0][BRC_SQN_W-1:0] sqn,
    output logic [IDX_W-1:0]                  win_idx,
    output logic                              win_valid
);

    logic                 node_valid [2*NUM_SRC];
    logic [BRC_SQN_W-1:0] node_sqn   [2*NUM_SRC];
    logic [IDX_W-1:0]     node_idx   [2*NUM_SRC];

    always_comb begin
        for (int n = 0; n < 2*NUM_SRC; n++) begin
            node_valid[n] = 1'b0;
            node_sqn[n]   = '0;
            node_idx[n]   = '0;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            node_valid[NUM_SRC+i] = valid[i];
            node_sqn[NUM_SRC+i]   = sqn[i];
            node_idx[NUM_SRC+i]   = IDX_W'(i);
        end
        // Right child only wins when strictly older, so ties resolve to the lower port.
        for (int n = NUM_SRC-1; n >= 1; n--) begin
            if (node_valid[2*n+1] &&
                (!node_valid[2*n] || sqn_older(node_sqn[2*n+1], node_sqn[2*n]))) begin
                node_sqn[n] = node_sqn[2*n+1];
                node_idx[n] = node_idx[2*n+1];
            end else begin
                node_sqn[n] = node_sqn[2*n];
                node_idx[n] = node_idx[2*n];
            end
            node_valid[n] = node_valid[2*n] | node_valid[2*n+1];
        end
        win_valid = node_valid[1];
        win_idx   = node_idx[1];
    end

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Branch recovery controller: issues the oldest redirect to the ROB and stalls rename through replay + drain.
// Optional macro BRCTRL_PERF_EN adds the misprediction pulse and stall-cycle performance counter ports.
module branch_recovery_ctrl
    import branch_recovery_ctrl_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int SQN_W     = BRC_SQN_W,
    parameter int FETCHID_W = BRC_FETCHID_W,
    parameter int PC_W      = BRC_PC_W,
    parameter int DRAIN_CYC = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_SRC-1:0]                  IN_reqValid,
    input  logic [NUM_SRC-1:0][SQN_W-1:0]       IN_reqSqN,
    input  logic [NUM_SRC-1:0]                  IN_reqFlush,
    input  logic [NUM_SRC-1:0][FETCHID_W-1:0]   IN_reqFetchID,
    input  logic [NUM_SRC-1:0][PC_W-1:0]        IN_reqDstPC,
    input  logic                                IN_mispredFlush,
    output logic                                OUT_brTaken,
    output logic [SQN_W-1:0]                    OUT_brSqN,
    output logic                                OUT_brFlush,
    output logic [FETCHID_W-1:0]                OUT_brFetchID,
    output logic [PC_W-1:0]                     OUT_brDstPC,
    output logic                                OUT_stallRename,
    output logic                                OUT_busy
`ifdef BRCTRL_PERF_EN
    ,
    output logic                                OUT_PERFC_mispr,
    output logic [31:0]                         OUT_PERFC_stallCyc
`endif
);

    localparam int IDX_W = $clog2(NUM_SRC);

    BrCtrlState_t           state;
    BrCtrlState_t           state_next;
    logic [3:0]             drain_cnt;
    logic [3:0]             drain_cnt_next;

    BrReq_t                 req [NUM_SRC];
    BrReq_t                 win_req;
    logic [NUM_SRC-1:0]     cand_valid;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_valid;

    // While a recovery is open, anything not older than the issued branch is on the squashed path.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            req[i].sqN     = IN_reqSqN[i];
            req[i].flush   = IN_reqFlush[i];
            req[i].fetchID = IN_reqFetchID[i];
            req[i].dstPC   = IN_reqDstPC[i];
            cand_valid[i]  = IN_reqValid[i] &
                             ((state == IDLE) | sqn_older(IN_reqSqN[i], OUT_brSqN));
        end
    end

    branch_oldest_sel #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_oldest_sel (
        .valid     (cand_valid),
        .sqn       (IN_reqSqN),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    assign win_req = req[win_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            drain_cnt     <= '0;
            OUT_brTaken   <= 1'b0;
            OUT_brSqN     <= '0;
            OUT_brFlush   <= 1'b0;
            OUT_brFetchID <= '0;
            OUT_brDstPC   <= '0;
        end else begin
            state       <= state_next;
            drain_cnt   <= drain_cnt_next;
            OUT_brTaken <= win_valid;
            if (win_valid) begin
                OUT_brSqN     <= win_req.sqN;
                OUT_brFlush   <= win_req.flush;
                OUT_brFetchID <= win_req.fetchID;
                OUT_brDstPC   <= win_req.dstPC;
            end
        end
    end

    // A surviving candidate always restarts the window, even in the cycle the replay ends.
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        if (win_valid) begin
            state_next     = WAIT_START;
            drain_cnt_next = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                WAIT_START: begin
                    if (IN_mispredFlush)
                        state_next = REPLAY;
                end
                REPLAY: begin
                    if (!IN_mispredFlush) begin
                        state_next     = DRAIN;
                        drain_cnt_next = 4'(DRAIN_CYC - 1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 4'd0)
                        state_next = IDLE;
                    else
                        drain_cnt_next = drain_cnt - 4'd1;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        OUT_busy        = (state != IDLE);
        OUT_stallRename = (state != IDLE) | OUT_brTaken;
    end

`ifdef BRCTRL_PERF_EN
    assign OUT_PERFC_mispr = OUT_brTaken;

    always_ff @(posedge clk) begin
        if (rst)
            OUT_PERFC_stallCyc <= '0;
        else if (OUT_stallRename && (OUT_PERFC_stallCyc != 32'hFFFF_FFFF))
            OUT_PERFC_stallCyc <= OUT_PERFC_stallCyc + 32'd1;
    end
`endif

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Self-checking bench for branch_recovery_ctrl: cycle model plus payload scoreboard.
// Build with BRCTRL_PERF_EN defined to also check the performance counter ports.
module tb_branch_recovery_ctrl;

    localparam int NS = 4;
    localparam int SW = 7;
    localparam int FW = 3;
    localparam int PW = 31;
    localparam int DC = 2;

    typedef struct packed {
        logic [SW-1:0] sqn;
        logic          flush;
        logic [FW-1:0] fid;
        logic [PW-1:0] pc;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NS-1:0]          req_valid;
    logic [NS-1:0][SW-1:0]  req_sqn;
    logic [NS-1:0]          req_flush;
    logic [NS-1:0][FW-1:0]  req_fid;
    logic [NS-1:0][PW-1:0]  req_pc;
    logic                   mispred_flush;
    logic                   br_taken;
    logic [SW-1:0]          br_sqn;
    logic                   br_flush;
    logic [FW-1:0]          br_fid;
    logic [PW-1:0]          br_pc;
    logic                   stall_rename;
    logic                   busy;
`ifdef BRCTRL_PERF_EN
    logic                   perf_mispr;
    logic [31:0]            perf_stall;
`endif

    exp_t        sbq[$];
    exp_t        m_hold;
    exp_t        got;
    int          checks = 0;
    int          errors = 0;
    int          m_state;
    int          m_cnt;
    logic        exp_taken;
    logic        prev_stall;
    int          m_perf;

    always #5 clk = ~clk;

    branch_recovery_ctrl #(
        .NUM_SRC   (NS),
        .SQN_W     (SW),
        .FETCHID_W (FW),
        .PC_W      (PW),
        .DRAIN_CYC (DC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .IN_reqValid     (req_valid),
        .IN_reqSqN       (req_sqn),
        .IN_reqFlush     (req_flush),
        .IN_reqFetchID   (req_fid),
        .IN_reqDstPC     (req_pc),
        .IN_mispredFlush (mispred_flush),
        .OUT_brTaken     (br_taken),
        .OUT_brSqN       (br_sqn),
        .OUT_brFlush     (br_flush),
        .OUT_brFetchID   (br_fid),
        .OUT_brDstPC     (br_pc),
        .OUT_stallRename (stall_rename),
        .OUT_busy        (busy)
`ifdef BRCTRL_PERF_EN
        ,
        .OUT_PERFC_mispr    (perf_mispr),
        .OUT_PERFC_stallCyc (perf_stall)
`endif
    );

    function automatic logic older(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW-1:0] d;
        d = a - b;
        return ($signed(d) < 0);
    endfunction

    function automatic exp_t mk_req(input int port, input logic [SW-1:0] s);
        exp_t r;
        r.sqn   = s;
        r.flush = s[0] ^ port[0];
        r.fid   = FW'(port) ^ s[2:0];
        r.pc    = {s, 22'h2A5A5, 2'(port)};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        chk("brTaken", 64'(br_taken), 64'(exp_taken));
        if (br_taken === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpectedPulse", 64'(1), 64'(0));
            end else begin
                got = sbq.pop_front();
                chk("brSqN", 64'(br_sqn), 64'(got.sqn));
                chk("brFlush", 64'(br_flush), 64'(got.flush));
                chk("brFetchID", 64'(br_fid), 64'(got.fid));
                chk("brDstPC", 64'(br_pc), 64'(got.pc));
            end
        end else begin
            chk("holdSqN", 64'(br_sqn), 64'(m_hold.sqn));
            chk("holdDstPC", 64'(br_pc), 64'(m_hold.pc));
        end
        chk("busy", 64'(busy), 64'(m_state != 0));
        chk("stallRename", 64'(stall_rename), 64'((m_state != 0) || exp_taken));
`ifdef BRCTRL_PERF_EN
        chk("perfMispr", 64'(perf_mispr), 64'(exp_taken));
        chk("perfStallCyc", 64'(perf_stall), 64'(m_perf));
`endif
        prev_stall = (m_state != 0) || exp_taken;
    endtask

    task automatic applyStimulus(input logic [NS-1:0] v,
                                 input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                                 input logic [SW-1:0] s2, input logic [SW-1:0] s3,
                                 input logic mf);
        logic [SW-1:0] s [NS];
        exp_t r;
        int best;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        best = -1;
        for (int i = 0; i < NS; i++) begin
            r = mk_req(i, s[i]);
            req_sqn[i]   = r.sqn;
            req_flush[i] = r.flush;
            req_fid[i]   = r.fid;
            req_pc[i]    = r.pc;
            if (v[i] && (m_state == 0 || older(s[i], m_hold.sqn)))
                if (best < 0 || older(s[i], s[best]))
                    best = i;
        end
        req_valid     = v;
        mispred_flush = mf;
        if (prev_stall)
            m_perf++;
        if (best >= 0) begin
            r = mk_req(best, s[best]);
            sbq.push_back(r);
            m_hold    = r;
            m_state   = 1;
            m_cnt     = 0;
            exp_taken = 1'b1;
        end else begin
            exp_taken = 1'b0;
            case (m_state)
                1: if (mf) m_state = 2;
                2: if (!mf) begin m_state = 3; m_cnt = DC - 1; end
                3: if (m_cnt == 0) m_state = 0; else m_cnt--;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic resetDut();
        rst           = 1'b1;
        req_valid     = '0;
        mispred_flush = 1'b0;
        @(posedge clk);
        #1;
        m_state    = 0;
        m_cnt      = 0;
        m_hold     = '0;
        exp_taken  = 1'b0;
        prev_stall = 1'b0;
        m_perf     = 0;
        sbq.delete();
        checkOutput();
        rst = 1'b0;
    endtask

    // Replay held for hi cycles, then enough quiet cycles to drain back to idle.
    task automatic recover(input int hi);
        repeat (hi) applyStimulus('0, '0, '0, '0, '0, 1'b1);
        repeat (DC + 1) applyStimulus('0, '0, '0, '0, '0, 1'b0);
        chk("idleAfterDrain", 64'(busy), 64'(0));
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = '0;
        req_sqn       = '0;
        req_flush     = '0;
        req_fid       = '0;
        req_pc        = '0;
        mispred_flush = 1'b0;
        m_hold        = '0;
        prev_stall    = 1'b0;
        m_perf        = 0;
        #2;
        resetDut();
        applyStimulus('0, '0, '0, '0, '0, 1'b0);

        applyStimulus(4'b0100, 7'h00, 7'h00, 7'h10, 7'h00, 1'b0);
        chk("t1SqN", 64'(br_sqn), 64'(7'h10));
        recover(1);

        applyStimulus(4'b1001, 7'h12, 7'h00, 7'h00, 7'h0F, 1'b0);
        chk("t2Oldest", 64'(br_sqn), 64'(7'h0F));
        recover(1);
        applyStimulus(4'b0110, 7'h00, 7'h30, 7'h30, 7'h00, 1'b0);
        chk("t2TiePort1", 64'(br_pc[1:0]), 64'(1));
        recover(1);

        applyStimulus(4'b0011, 7'h7E, 7'h02, 7'h00, 7'h00, 1'b0);
        chk("t3Wrap", 64'(br_sqn), 64'(7'h7E));
        recover(1);

        applyStimulus(4'b0001, 7'h20, 7'h00, 7'h00, 7'h00, 1'b0);
        applyStimulus('0, '0, '0, '0, '0, 1'b1);
        applyStimulus(4'b0100, 7'h00, 7'h00, 7'h25, 7'h00, 1'b1);
        chk("t4Dropped", 64'(br_taken), 64'(0));
        applyStimulus(4'b1000, 7'h00, 7'h00, 7'h00, 7'h1C, 1'b1);
        chk("t4Nested", 64'(br_sqn), 64'(7'h1C));
        recover(1);

        applyStimulus(4'b0001, 7'h40, 7'h00, 7'h00, 7'h00, 1'b0);
        applyStimulus('0, '0, '0, '0, '0, 1'b1);
        applyStimulus(4'b0010, 7'h00, 7'h3E, 7'h00, 7'h00, 1'b0);
        chk("candBeatsFall", 64'(busy), 64'(1));
        recover(1);

        applyStimulus(4'b0001, 7'h50, 7'h00, 7'h00, 7'h00, 1'b0);
        recover(3);

        applyStimulus(4'b1111, 7'h05, 7'h03, 7'h04, 7'h03, 1'b0);
        recover(2);

        applyStimulus(4'b0001, 7'h60, 7'h00, 7'h00, 7'h00, 1'b0);
        applyStimulus('0, '0, '0, '0, '0, 1'b1);
        applyStimulus('0, '0, '0, '0, '0, 1'b1);
        resetDut();
        chk("rstSqN", 64'(br_sqn), 64'(0));
        applyStimulus('0, '0, '0, '0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
